cpe_checker: RTL

Pipelined checker for the 15-bit CPE codewords emitted by the adder+CPE generator stage. It accepts codewords over a valid/ready handshake and recomputes the BCH(15,7) syndrome. It returns the 7-bit data word, optionally with single-bit correction, and keeps a saturating error counter plus a sticky alarm FSM for the fault monitor.

---
 rtl/cpe_pkg.sv | 25 ++
 rtl/cpe_checker_if.sv | 21 ++
 rtl/cpe_syndrome.sv | 26 ++
 rtl/cpe_checker.sv | 85 ++++++++
 4 files changed

// File: rtl/cpe_pkg.sv
// cpe_pkg: shared BCH(15,7) constants, FSM state type and syndrome helpers for cpe_checker.
package cpe_pkg;
    localparam int NBIT  = 7;
    localparam int NCODE = 15;
    localparam int NPAR  = NCODE - NBIT;
    localparam logic [NPAR:0] G_POLY = 9'h1D1;

    typedef enum logic {MON, ALM} state_t;

    // Entry k is x^k mod g: the syndrome seen when only codeword bit k is flipped.
    localparam logic [NCODE-1:0][NPAR-1:0] SYN_TAB = {
        8'hE8, 8'h74, 8'h3A, 8'h1D, 8'hE6, 8'h73, 8'hD1,
        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [NPAR-1:0] syndrome(input logic [NCODE-1:0] code);
        logic [NPAR:0] r;
        r = '0;
        for (int i = NCODE - 1; i >= 0; i--) begin
            r = {r[NPAR-1:0], code[i]};
            if (r[NPAR]) r = r ^ G_POLY;
        end
        return r[NPAR-1:0];
    endfunction
endpackage

// File: rtl/cpe_checker_if.sv
// cpe_checker_if: codeword input and result output handshakes of cpe_checker.
interface cpe_checker_if;
    import cpe_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [NCODE-1:0] in_code;
    logic             out_valid;
    logic             out_ready;
    logic [NBIT-1:0]  out_data;
    logic             out_err;
    logic             out_corr;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_corr
    );
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_err, out_corr
    );
endinterface

// File: rtl/cpe_syndrome.sv
// cpe_syndrome: classifies a stage-1 syndrome and repairs single-bit errors.
// Correction is built only when CPE_CHK_CORRECT_EN is defined; otherwise detection only.
module cpe_syndrome
    import cpe_pkg::*;
(
    input  logic [NBIT-1:0] data_in,
    input  logic [NPAR-1:0] syn,
    output logic [NBIT-1:0] data_out,
    output logic            err,
    output logic            corr
);
`ifdef CPE_CHK_CORRECT_EN
    logic [NCODE-1:0] hit;
    for (genvar k = 0; k < NCODE; k++) begin : g_hit
        assign hit[k] = (syn == SYN_TAB[k]);
    end
    // A hit on a parity position leaves the data bits untouched.
    assign data_out = data_in ^ hit[NCODE-1:NPAR];
    assign corr     = |hit;
    assign err      = (|syn) && !corr;
`else
    assign data_out = data_in;
    assign corr     = 1'b0;
    assign err      = |syn;
`endif
endmodule

// File: rtl/cpe_checker.sv
// cpe_checker: two-stage BCH(15,7) checker with saturating error counter and sticky alarm.
module cpe_checker
    import cpe_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cpe_checker_if.slave      bus,
    input  logic              clr_alarm,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              alarm
);
    logic             en, inc;
    logic             v1_q, v1_d;
    logic [NBIT-1:0]  data1_q, data1_d;
    logic [NPAR-1:0]  syn1_q, syn1_d;
    logic             ov_q, ov_d, oe_q, oe_d, oc_q, oc_d;
    logic [NBIT-1:0]  od_q, od_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             alarm_q, alarm_d;
    logic [NBIT-1:0]  fix_data;
    logic             fix_err, fix_corr;

    cpe_syndrome u_syn (
        .data_in  (data1_q),
        .syn      (syn1_q),
        .data_out (fix_data),
        .err      (fix_err),
        .corr     (fix_corr)
    );

    // Both stages share one advance so a stall freezes the whole pipe.
    always_comb begin
        en      = !ov_q || bus.out_ready;
        v1_d    = en ? bus.in_valid : v1_q;
        data1_d = en ? bus.in_code[NCODE-1:NPAR] : data1_q;
        syn1_d  = en ? syndrome(bus.in_code) : syn1_q;
        ov_d    = en ? v1_q : ov_q;
        od_d    = en ? fix_data : od_q;
        oe_d    = en ? fix_err : oe_q;
        oc_d    = en ? fix_corr : oc_q;
        inc     = en && v1_q && (|syn1_q);
        cnt_d   = clr_alarm ? CNT_W'(inc)
                : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        state_d = ((state_q == ALM && !clr_alarm) || (inc && cnt_d == CNT_W'(ALARM_TH))) ? ALM : MON;
        alarm_d = (state_d == ALM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            data1_q <= '0;
            syn1_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            oe_q    <= 1'b0;
            oc_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= MON;
            alarm_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            data1_q <= data1_d;
            syn1_q  <= syn1_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            oe_q    <= oe_d;
            oc_q    <= oc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            alarm_q <= alarm_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_err   = oe_q;
    assign bus.out_corr  = oc_q;
    assign err_cnt       = cnt_q;
    assign alarm         = alarm_q;
endmodule
